// File: rtl/composer_pkg.sv
// rtl/composer_pkg.sv - register map, display mode encodings and reset constants for the layer composer
package composer_pkg;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_HSCALE = 5'd1;
  localparam logic [4:0] REG_BORDER = 5'd2;
  localparam logic [4:0] REG_HSTART = 5'd3;
  localparam logic [4:0] REG_HSTOP  = 5'd4;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_VGA  = 2'd1,
    MODE_NTSC = 2'd2,
    MODE_RGBI = 2'd3
  } mode_e;

  localparam logic [2:0] CTRL_RST   = 3'd0;
  localparam logic [7:0] BORDER_RST = 8'd0;
  localparam logic [7:0] HSTART_RST = 8'd0;

endpackage

// File: rtl/layer_priority_mux.sv
// rtl/layer_priority_mux.sv - combinational Z-ordered merge of N layers and one sprite pixel
module layer_priority_mux #(
  parameter int NUM_LAYERS = 2,
  parameter int Z_W        = 2
) (
  input  logic [8*NUM_LAYERS-1:0] i_layer_data,
  input  logic [NUM_LAYERS-1:0]   i_layer_en,
  input  logic                    i_sprite_en,
  input  logic [7:0]              i_sprite_colour,
  input  logic [Z_W-1:0]          i_sprite_z,
  output logic [7:0]              o_pixel
);

  logic w_sprite_vis;
  assign w_sprite_vis = i_sprite_en && (i_sprite_colour != 8'd0) && (i_sprite_z != '0);

  // Paint bottom to top; a sprite with Z=i+1 sits just beneath layer i, Z above N is on top
  always_comb begin
    o_pixel = 8'd0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_sprite_vis && (i_sprite_z == Z_W'(i + 1)))
        o_pixel = i_sprite_colour;
      if (i_layer_en[i] && (i_layer_data[8*i +: 8] != 8'd0))
        o_pixel = i_layer_data[8*i +: 8];
    end
    if (w_sprite_vis && ({1'b0, i_sprite_z} >= (Z_W+1)'(NUM_LAYERS + 1)))
      o_pixel = i_sprite_colour;
  end

endmodule

// File: rtl/layer_composer.sv
// rtl/layer_composer.sv - per-pixel compositor with scaled X stepping, active window and sprite clear
module layer_composer
  import composer_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int Z_W        = 2,
  parameter int LB_IDX_W   = 10,
  parameter int LINE_W     = 640,
  parameter int LINE_IDX_W = 9,
  parameter int FRAC_W     = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              regs_addr,
  input  logic [7:0]              regs_wrdata,
  output logic [7:0]              regs_rddata,
  input  logic                    regs_write,
  output logic [LINE_IDX_W-1:0]   layer_line_idx,
  output logic                    layer_render_start,
  input  logic [NUM_LAYERS-1:0]   layer_enabled,
  output logic [LB_IDX_W-1:0]     layer_lb_rdidx,
  input  logic [8*NUM_LAYERS-1:0] layer_lb_rddata,
  input  logic                    sprites_enabled,
  input  logic [15:0]             sprites_lb_rddata,
  output logic [LB_IDX_W-1:0]     sprites_lb_wridx,
  output logic [15:0]             sprites_lb_wrdata,
  output logic                    sprites_lb_wren,
  input  logic [LINE_IDX_W-1:0]   display_line_idx,
  input  logic                    display_start_of_screen,
  input  logic                    display_start_of_line,
  input  logic                    display_next_pixel,
  output logic [7:0]              display_data,
  output logic [1:0]              display_mode,
  output logic                    chroma_disable
);

  localparam int X_W   = LB_IDX_W + FRAC_W;
  localparam int COL_W = $clog2(LINE_W + 1);
  localparam int CMP_W = ((COL_W > 10) ? COL_W : 10) + 1;
  localparam logic [7:0] HSCALE_RST = 8'(1 << FRAC_W);
  localparam logic [7:0] HSTOP_RST  = 8'(LINE_W / 4);

  logic [2:0]          r_ctrl;
  logic [7:0]          r_hscale, r_border, r_hstart, r_hstop;
  logic [7:0]          r_hscale_sh, r_hstart_sh, r_hstop_sh;
  logic                r_render_start;
  logic [COL_W-1:0]    r_col;
  logic [X_W-1:0]      r_x;
  logic                r_pend, r_wren;
  logic [LB_IDX_W-1:0] r_wridx;
  logic [7:0]          r_data;

  mode_e               w_mode;
  logic                w_half, w_in_win, w_pixel;
  logic [7:0]          w_scale, w_mux;
  logic [LB_IDX_W-1:0] w_rdidx;
  logic                w_unused;

  assign w_mode   = mode_e'(r_ctrl[1:0]);
  assign w_half   = (w_mode == MODE_NTSC) || (w_mode == MODE_RGBI);
  assign w_scale  = w_half ? {1'b0, r_hscale_sh[7:1]} : r_hscale_sh;
  assign w_rdidx  = r_x[X_W-1:FRAC_W];
  assign w_pixel  = display_next_pixel && !display_start_of_line;
  assign w_in_win = (CMP_W'(r_col) >= CMP_W'({r_hstart_sh, 2'b00}))
                 && (CMP_W'(r_col) <  CMP_W'({r_hstop_sh, 2'b00}))
                 && (CMP_W'(r_col) <  CMP_W'(LINE_W));
  assign w_unused = &{1'b0, sprites_lb_rddata[15:8+Z_W]};

  assign layer_line_idx     = display_line_idx;
  assign layer_render_start = r_render_start;
  assign layer_lb_rdidx     = w_rdidx;
  assign sprites_lb_wridx   = r_wridx;
  assign sprites_lb_wrdata  = 16'h0000;
  assign sprites_lb_wren    = r_wren;
  assign display_data       = r_data;
  assign display_mode       = r_ctrl[1:0];
  assign chroma_disable     = r_ctrl[2];

  // Register file writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= CTRL_RST;
      r_hscale <= HSCALE_RST;
      r_border <= BORDER_RST;
      r_hstart <= HSTART_RST;
      r_hstop  <= HSTOP_RST;
    end else if (regs_write) begin
      case (regs_addr)
        REG_CTRL:   r_ctrl   <= regs_wrdata[2:0];
        REG_HSCALE: r_hscale <= regs_wrdata;
        REG_BORDER: r_border <= regs_wrdata;
        REG_HSTART: r_hstart <= regs_wrdata;
        REG_HSTOP:  r_hstop  <= regs_wrdata;
        default: ;
      endcase
    end
  end

  // Register readback, combinational
  always_comb begin
    regs_rddata = 8'h00;
    case (regs_addr)
      REG_CTRL:   regs_rddata = {5'b0, r_ctrl};
      REG_HSCALE: regs_rddata = r_hscale;
      REG_BORDER: regs_rddata = r_border;
      REG_HSTART: regs_rddata = r_hstart;
      REG_HSTOP:  regs_rddata = r_hstop;
      default:    regs_rddata = 8'h00;
    endcase
  end

  // Frame-aligned shadows so geometry never changes mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hscale_sh <= HSCALE_RST;
      r_hstart_sh <= HSTART_RST;
      r_hstop_sh  <= HSTOP_RST;
    end else if (display_start_of_screen) begin
      r_hscale_sh <= r_hscale;
      r_hstart_sh <= r_hstart;
      r_hstop_sh  <= r_hstop;
    end
  end

  // Column and fractional X counters; line start wins over a coincident pixel strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col          <= '0;
      r_x            <= '0;
      r_render_start <= 1'b0;
    end else begin
      r_render_start <= display_start_of_line;
      if (display_start_of_line) begin
        r_col <= '0;
        r_x   <= '0;
      end else if (display_next_pixel) begin
        if (w_in_win && (w_rdidx < LB_IDX_W'(LINE_W - 1)))
          r_x <= r_x + X_W'(w_scale);
        if (r_col != COL_W'(LINE_W))
          r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Pixel pipeline stage: remember window state and read index for the clear write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_wren  <= 1'b0;
      r_wridx <= '0;
    end else begin
      r_pend <= w_pixel;
      r_wren <= w_pixel && w_in_win;
      if (w_pixel)
        r_wridx <= w_rdidx;
    end
  end

  // Output register: composed colour inside the window, border colour outside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_data <= 8'd0;
    else if (r_pend)
      r_data <= r_wren ? w_mux : r_border;
  end

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .Z_W        (Z_W)
  ) u_priority_mux (
    .i_layer_data    (layer_lb_rddata),
    .i_layer_en      (layer_enabled),
    .i_sprite_en     (sprites_enabled),
    .i_sprite_colour (sprites_lb_rddata[7:0]),
    .i_sprite_z      (sprites_lb_rddata[8 +: Z_W]),
    .o_pixel         (w_mux)
  );

endmodule

// File: tb/tb_layer_composer.sv
// tb/tb_layer_composer.sv - self-checking bench for layer_composer
module tb_layer_composer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  regs_addr;
  logic [7:0]  regs_wrdata;
  logic [7:0]  regs_rddata;
  logic        regs_write;
  logic [8:0]  layer_line_idx;
  logic        layer_render_start;
  logic [1:0]  layer_enabled;
  logic [9:0]  layer_lb_rdidx;
  logic [15:0] layer_lb_rddata;
  logic        sprites_enabled;
  logic [15:0] sprites_lb_rddata;
  logic [9:0]  sprites_lb_wridx;
  logic [15:0] sprites_lb_wrdata;
  logic        sprites_lb_wren;
  logic [8:0]  display_line_idx;
  logic        display_start_of_screen;
  logic        display_start_of_line;
  logic        display_next_pixel;
  logic [7:0]  display_data;
  logic [1:0]  display_mode;
  logic        chroma_disable;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  l0_mem [1024];
  logic [7:0]  l1_mem [1024];
  logic [15:0] spr_mem [1024];
  logic [15:0] spr_model [1024];

  typedef struct {
    logic [7:0] l0;
    logic [7:0] l1;
    logic [7:0] sc;
    logic [1:0] z;
    logic [1:0] len;
    logic       sen;
    logic [7:0] exp;
  } vec_t;

  layer_composer dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .regs_addr               (regs_addr),
    .regs_wrdata             (regs_wrdata),
    .regs_rddata             (regs_rddata),
    .regs_write              (regs_write),
    .layer_line_idx          (layer_line_idx),
    .layer_render_start      (layer_render_start),
    .layer_enabled           (layer_enabled),
    .layer_lb_rdidx          (layer_lb_rdidx),
    .layer_lb_rddata         (layer_lb_rddata),
    .sprites_enabled         (sprites_enabled),
    .sprites_lb_rddata       (sprites_lb_rddata),
    .sprites_lb_wridx        (sprites_lb_wridx),
    .sprites_lb_wrdata       (sprites_lb_wrdata),
    .sprites_lb_wren         (sprites_lb_wren),
    .display_line_idx        (display_line_idx),
    .display_start_of_screen (display_start_of_screen),
    .display_start_of_line   (display_start_of_line),
    .display_next_pixel      (display_next_pixel),
    .display_data            (display_data),
    .display_mode            (display_mode),
    .chroma_disable          (chroma_disable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_reg(input int a, input int d);
    @(negedge clk);
    regs_addr = 5'(a); regs_wrdata = 8'(d); regs_write = 1'b1;
    @(negedge clk);
    regs_write = 1'b0;
  endtask

  task automatic sos();
    @(negedge clk); display_start_of_screen = 1'b1;
    @(negedge clk); display_start_of_screen = 1'b0;
  endtask

  task automatic sol();
    @(negedge clk); display_start_of_line = 1'b1;
    @(negedge clk); display_start_of_line = 1'b0;
    chk("render_start", int'(layer_render_start), 1);
  endtask

  // One pixel: strobe, serve line-buffer reads from the index the DUT presents, apply clears, sample output
  task automatic pixel(output int idx, output int wr, output int wi, output int dat);
    @(negedge clk);
    display_next_pixel = 1'b1;
    idx = int'(layer_lb_rdidx);
    @(negedge clk);
    display_next_pixel = 1'b0;
    layer_lb_rddata   = {l1_mem[idx], l0_mem[idx]};
    sprites_lb_rddata = spr_mem[idx];
    wr = int'(sprites_lb_wren);
    wi = int'(sprites_lb_wridx);
    if (sprites_lb_wren) spr_mem[sprites_lb_wridx] = 16'h0000;
    @(negedge clk);
    dat = int'(display_data);
  endtask

  // Reference: topmost opaque item wins, scanning from the top of the stack downward
  function automatic int compose_ref(logic [7:0] a, logic [7:0] b, logic [15:0] s,
                                     logic [1:0] len, logic sen);
    int   z;
    logic sv;
    z  = int'(s[9:8]);
    sv = sen && (s[7:0] != 8'd0);
    if (sv && z >= 3) return int'(s[7:0]);
    if (len[1] && b != 8'd0) return int'(b);
    if (sv && z == 2) return int'(s[7:0]);
    if (len[0] && a != 8'd0) return int'(a);
    if (sv && z == 1) return int'(s[7:0]);
    return 0;
  endfunction

  task automatic clear_mems();
    for (int i = 0; i < 1024; i++) begin
      l0_mem[i] = 8'd0; l1_mem[i] = 8'd0; spr_mem[i] = 16'd0;
    end
  endtask

  initial begin
    int   a_idx, a_wr, a_wi, a_dat;
    int   rst_vals [6];
    vec_t vecs [8];

    rst_vals = '{0, 'h80, 0, 0, 'hA0, 0};
    vecs[0] = '{8'h11, 8'h22, 8'h33, 2'd1, 2'b11, 1'b1, 8'h22};
    vecs[1] = '{8'h11, 8'h22, 8'h33, 2'd2, 2'b11, 1'b1, 8'h22};
    vecs[2] = '{8'h11, 8'h22, 8'h33, 2'd3, 2'b11, 1'b1, 8'h33};
    vecs[3] = '{8'h11, 8'h22, 8'h33, 2'd2, 2'b01, 1'b1, 8'h33};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 2'd3, 2'b11, 1'b1, 8'h00};
    vecs[5] = '{8'h11, 8'h22, 8'h33, 2'd0, 2'b00, 1'b1, 8'h11};
    vecs[6] = '{8'h11, 8'h00, 8'h33, 2'd1, 2'b11, 1'b1, 8'h11};
    vecs[7] = '{8'h11, 8'h22, 8'h33, 2'd3, 2'b11, 1'b0, 8'h22};
    vecs[5].len = 2'b00;
    vecs[5].exp = 8'h00;

    rst_n = 1'b0; regs_addr = '0; regs_wrdata = '0; regs_write = 1'b0;
    layer_enabled = 2'b11; layer_lb_rddata = '0; sprites_enabled = 1'b1;
    sprites_lb_rddata = '0; display_line_idx = 9'd37; display_start_of_screen = 1'b0;
    display_start_of_line = 1'b0; display_next_pixel = 1'b0;
    clear_mems();

    // 1: reset state and register map
    repeat (3) @(negedge clk);
    chk("rst_display_data", int'(display_data), 0);
    chk("rst_wren", int'(sprites_lb_wren), 0);
    chk("rst_wridx", int'(sprites_lb_wridx), 0);
    chk("rst_render_start", int'(layer_render_start), 0);
    chk("rst_rdidx", int'(layer_lb_rdidx), 0);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      @(negedge clk); regs_addr = 5'(a); #1;
      chk($sformatf("rst_reg%0d", a), int'(regs_rddata), rst_vals[a]);
    end
    chk("line_idx", int'(layer_line_idx), 37);
    wr_reg(0, 'h06);
    chk("display_mode", int'(display_mode), 2);
    chk("chroma_disable", int'(chroma_disable), 1);
    wr_reg(9, 'hFF);
    regs_addr = 5'd9; #1;
    chk("unmapped_read", int'(regs_rddata), 0);

    // 2: fractional stepping, then halved step in NTSC mode
    wr_reg(0, 0); wr_reg(1, 'h40); sos(); sol();
    @(negedge clk);
    chk("render_start_pulse", int'(layer_render_start), 0);
    for (int i = 0; i < 8; i++) begin
      pixel(a_idx, a_wr, a_wi, a_dat);
      chk($sformatf("step_half_%0d", i), a_idx, i / 2);
    end
    wr_reg(0, 2); sos(); sol();
    for (int i = 0; i < 16; i++) begin
      pixel(a_idx, a_wr, a_wi, a_dat);
      chk($sformatf("step_quarter_%0d", i), a_idx, i / 4);
    end
    wr_reg(0, 0); wr_reg(1, 'h80); sos();

    // 3: composition table
    foreach (vecs[v]) begin
      clear_mems();
      l0_mem[0] = vecs[v].l0; l1_mem[0] = vecs[v].l1;
      spr_mem[0] = {6'd0, vecs[v].z, vecs[v].sc};
      layer_enabled = vecs[v].len; sprites_enabled = vecs[v].sen;
      sol();
      pixel(a_idx, a_wr, a_wi, a_dat);
      chk($sformatf("compose_vec%0d", v), a_dat, int'(vecs[v].exp));
      chk($sformatf("compose_clear%0d", v), int'(spr_mem[0]), 0);
    end
    layer_enabled = 2'b11; sprites_enabled = 1'b1;

    // 4: window and border
    clear_mems();
    wr_reg(3, 2); wr_reg(4, 4); wr_reg(2, 'h5A); sos(); sol();
    for (int c = 0; c < 640; c++) begin
      pixel(a_idx, a_wr, a_wi, a_dat);
      if (c >= 8 && c < 16) begin
        chk("win_data", a_dat, 0);
        chk("win_wren", a_wr, 1);
        chk("win_wridx", a_wi, c - 8);
      end else begin
        chk("border_data", a_dat, 'h5A);
        chk("border_wren", a_wr, 0);
      end
    end
    wr_reg(3, 0); wr_reg(4, 160); sos();

    // 5: mid-frame HSCALE write is deferred to the next frame
    sol();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) wr_reg(1, 'h40);
      pixel(a_idx, a_wr, a_wi, a_dat);
      chk("midframe_step", a_idx, i);
    end
    sos(); sol();
    for (int i = 0; i < 4; i++) begin
      pixel(a_idx, a_wr, a_wi, a_dat);
      chk("newframe_step", a_idx, i / 2);
    end
    @(negedge clk); display_start_of_line = 1'b1; display_next_pixel = 1'b1;
    @(negedge clk); display_start_of_line = 1'b0; display_next_pixel = 1'b0;
    chk("sol_wins_rdidx", int'(layer_lb_rdidx), 0);
    chk("sol_wins_wren", int'(sprites_lb_wren), 0);

    // Randomised lines against the reference model
    for (int ln = 0; ln < 4; ln++) begin
      int hs, he, sc, md, brd, scl, x, col, eidx, ewin, edat;
      logic [1:0] len;
      logic       sen;
      hs = $urandom_range(0, 60); he = $urandom_range(0, 170);
      sc = $urandom_range(1, 255); md = $urandom_range(0, 3); brd = $urandom_range(0, 255);
      len = 2'($urandom_range(0, 3)); sen = 1'($urandom_range(0, 1));
      layer_enabled = len; sprites_enabled = sen;
      for (int i = 0; i < 1024; i++) begin
        l0_mem[i]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        l1_mem[i]  = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
        spr_mem[i] = 16'($urandom);
        spr_model[i] = spr_mem[i];
      end
      wr_reg(0, md); wr_reg(1, sc); wr_reg(2, brd); wr_reg(3, hs); wr_reg(4, he);
      sos(); sol();
      scl = (md >= 2) ? (sc / 2) : sc;
      x = 0; col = 0;
      for (int p = 0; p < 660; p++) begin
        pixel(a_idx, a_wr, a_wi, a_dat);
        eidx = x / 128;
        ewin = (col >= 4 * hs && col < 4 * he && col < 640) ? 1 : 0;
        chk("rnd_rdidx", a_idx, eidx);
        chk("rnd_wren", a_wr, ewin);
        if (ewin == 1) begin
          edat = compose_ref(l0_mem[eidx], l1_mem[eidx], spr_model[eidx], len, sen);
          spr_model[eidx] = 16'd0;
          chk("rnd_wridx", a_wi, eidx);
        end else begin
          edat = brd;
        end
        chk("rnd_data", a_dat, edat);
        if (ewin == 1 && eidx < 639) x = x + scl;
        if (col < 640) col = col + 1;
      end
    end

    // 6: asynchronous reset mid-line
    wr_reg(0, 0); wr_reg(1, 'h80); wr_reg(3, 0); wr_reg(4, 160); sos();
    clear_mems();
    for (int i = 0; i < 4; i++) l0_mem[i] = 8'h77;
    layer_enabled = 2'b01;
    sol();
    pixel(a_idx, a_wr, a_wi, a_dat);
    chk("pre_reset_data", a_dat, 'h77);
    @(negedge clk); display_next_pixel = 1'b1;
    @(negedge clk); display_next_pixel = 1'b0;
    chk("pre_reset_wren", int'(sprites_lb_wren), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", int'(display_data), 0);
    chk("async_rst_wren", int'(sprites_lb_wren), 0);
    chk("async_rst_rdidx", int'(layer_lb_rdidx), 0);
    regs_addr = 5'd1; #1;
    chk("async_rst_hscale", int'(regs_rddata), 'h80);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
